// File: rtl/pulse_burst_gen.sv
// Burst pulse generator: N pulses of programmable high/low width on a flop output.
// Define PULSE_ABORT_EN to add the abort input that cancels a running burst.
module pulse_burst_gen #(
    parameter int CNT_W = 4,
    parameter int WID_W = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic [WID_W-1:0] high_len,
    input  logic [WID_W-1:0] low_len,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
`ifdef PULSE_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WID_W-1:0] WID_ONE = WID_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WID_W-1:0] phase_q, phase_d;
    logic [WID_W-1:0] hlen_q, hlen_d;
    logic [WID_W-1:0] llen_q, llen_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_req;

`ifdef PULSE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // A zero length field still yields a one-cycle phase.
    function automatic logic [WID_W-1:0] eff_len(input logic [WID_W-1:0] v);
        return (v == '0) ? WID_ONE : v;
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hlen_d  = hlen_q;
        llen_d  = llen_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_pulses != '0) begin
                        hlen_d  = eff_len(high_len);
                        llen_d  = eff_len(low_len);
                        phase_d = eff_len(high_len);
                        rem_d   = n_pulses;
                        state_d = HIGH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HIGH: begin
                if (abort_req) begin
                    state_d = DONE;
                end else if (phase_q == WID_ONE) begin
                    rem_d = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        phase_d = llen_q;
                    end
                end else begin
                    phase_d = phase_q - WID_ONE;
                end
            end
            LOW: begin
                if (abort_req) begin
                    state_d = DONE;
                end else if (phase_q == WID_ONE) begin
                    state_d = HIGH;
                    phase_d = hlen_q;
                end else begin
                    phase_d = phase_q - WID_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they come straight off flops.
        pulse_d = (state_d == HIGH);
        busy_d  = (state_d == HIGH) || (state_d == LOW);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            hlen_q  <= '0;
            llen_q  <= '0;
            rem_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hlen_q  <= hlen_d;
            llen_q  <= llen_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen with a per-cycle expected-output scoreboard.
// Abort scenarios are exercised when PULSE_ABORT_EN is defined.
module tb_pulse_burst_gen;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] n_pulses;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [3:0] remaining;
    logic       abort;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;

    // {pulse_out, busy, done, remaining}
    logic [6:0] exp_q[$];

    logic [3:0] cnt4 = 4'd0;
    logic [3:0] base;
    logic [3:0] diff;

    always #5 CLK = ~CLK;

    always @(posedge pulse_out) cnt4 <= cnt4 + 4'd1;

    pulse_burst_gen #(.CNT_W(4), .WID_W(8)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .n_pulses  (n_pulses),
        .high_len  (high_len),
        .low_len   (low_len),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
`ifdef PULSE_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model of one burst as a list of per-cycle outputs, cycle k+1 onward.
    task automatic build(input int n, input int h, input int l, input int abort_at);
        int eh;
        int el;
        int c;
        logic [3:0] r;
        eh = (h == 0) ? 1 : h;
        el = (l == 0) ? 1 : l;
        c = 0;
        if (n == 0) begin
            exp_q.push_back({3'b001, 4'd0});
            exp_q.push_back({3'b000, 4'd0});
            return;
        end
        for (int i = 0; i < n; i++) begin
            r = 4'(n - i);
            for (int j = 0; j < eh; j++) begin
                c++;
                exp_q.push_back({3'b110, r});
                if (c == abort_at) begin
                    exp_q.push_back({3'b001, r});
                    exp_q.push_back({3'b000, r});
                    return;
                end
            end
            if (i < n - 1) begin
                r = 4'(n - i - 1);
                for (int j = 0; j < el; j++) begin
                    c++;
                    exp_q.push_back({3'b010, r});
                    if (c == abort_at) begin
                        exp_q.push_back({3'b001, r});
                        exp_q.push_back({3'b000, r});
                        return;
                    end
                end
            end
        end
        exp_q.push_back({3'b001, 4'd0});
        exp_q.push_back({3'b000, 4'd0});
    endtask

    task automatic run(input string tag, input int n, input int h, input int l,
                       input int abort_at, input int inj_at);
        int c;
        logic [6:0] e;
        build(n, h, l, abort_at);
        @(negedge CLK);
        start    = 1'b1;
        n_pulses = 4'(n);
        high_len = 8'(h);
        low_len  = 8'(l);
        @(posedge CLK);
        #1;
        start    = 1'b0;
        n_pulses = 4'($urandom);
        high_len = 8'($urandom);
        low_len  = 8'($urandom);
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, {pulse_out, busy, done, remaining}, e);
            if (busy) busy_cnt++;
            if (c == inj_at) begin
                start    = 1'b1;
                n_pulses = 4'd9;
                high_len = 8'd5;
                low_len  = 8'd4;
            end else begin
                start = 1'b0;
            end
            abort = (c == abort_at);
            c++;
            @(posedge CLK);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        n_pulses = 4'd0;
        high_len = 8'd0;
        low_len  = 8'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", {pulse_out, busy, done, remaining}, 7'd0);
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_after_reset", {pulse_out, busy, done, remaining}, 7'd0);

        run("n3_h2_l1", 3, 2, 1, 0, 0);
        run("n0", 0, 5, 5, 0, 0);

        base = cnt4;
        busy_cnt = 0;
        run("n15_h0_l0", 15, 0, 0, 0, 0);
        checks++;
        assert (busy_cnt == 29) else begin
            failures++;
            $error("FAIL n15_busy_cycles observed=%0d expected=29", busy_cnt);
        end
        diff = cnt4 - base;
        checks++;
        assert (diff === 4'd15) else begin
            failures++;
            $error("FAIL n15_edge_count observed=%0d expected=15", diff);
        end

        run("start_in_high", 3, 2, 1, 0, 1);
        run("start_in_low", 2, 3, 2, 0, 5);
        run("n1_h1_l1", 1, 1, 1, 0, 0);
        run("n2_h4_l3", 2, 4, 3, 0, 0);

        // Reset in cycle k+4 of an N=3,H=2,L=1 burst
        @(negedge CLK);
        start    = 1'b1;
        n_pulses = 4'd3;
        high_len = 8'd2;
        low_len  = 8'd1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("pre_reset_k4", {pulse_out, busy, done, remaining}, {3'b110, 4'd2});
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", {pulse_out, busy, done, remaining}, 7'd0);
        @(negedge CLK);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            check("post_reset_idle", {pulse_out, busy, done, remaining}, 7'd0);
        end
        run("after_reset", 3, 2, 1, 0, 0);

`ifdef PULSE_ABORT_EN
        run("abort_low", 3, 2, 1, 3, 0);
        run("abort_last_high", 2, 2, 2, 6, 0);
        run("n3_after_abort", 3, 1, 2, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
